// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: read-response owner encoding
// and a helper for sizing the starvation counter.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_PROC = 2'd1,
      OWN_DBG  = 2'd2
   } rd_owner_e;

   // Bits needed to hold the values 0..max inclusive.
   function automatic int cnt_width(input int max);
      if (max < 1) begin
         return 1;
      end else begin
         return $clog2(max + 1);
      end
   endfunction

endpackage

// File: rtl/dmem_arbiter_starve_ctr.sv
// Saturating up-counter with synchronous clear; counts cycles a requester
// has been refused and sticks at MAX until cleared.
module arb_starve_ctr #(
   parameter int WIDTH = 3,
   parameter int MAX   = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

   logic [WIDTH-1:0] cnt_r;

   // Clear has priority over increment; increment stops at MAX.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_r <= '0;
      end else if (clr) begin
         cnt_r <= '0;
      end else if (inc && (cnt_r != MAX_C)) begin
         cnt_r <= cnt_r + WIDTH'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt = cnt_r;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the processor (fixed priority)
// and a debug/loader requester, with bounded debug wait and read routing.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              p_req,
   input  logic              p_we,
   input  logic [ADDR_W-1:0] p_addr,
   input  logic [DATA_W-1:0] p_wdata,
   output logic              p_gnt,
   output logic              p_rvalid,
   output logic [DATA_W-1:0] p_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              wren,
   output logic [ADDR_W-1:0] address_dmem,
   output logic [DATA_W-1:0] data,
   input  logic [DATA_W-1:0] q_dmem
);

   localparam int             CNT_W = cnt_width(MAX_WAIT);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] starve_cnt_s;
   logic             force_d_s;
   logic             d_gnt_s;
   logic             p_gnt_s;
   rd_owner_e        rd_owner_r;
   rd_owner_e        rd_owner_nxt_s;

   // Grants are gated by reset so nothing reaches the RAM while it is asserted.
   assign force_d_s = d_req && (starve_cnt_s == MAX_C);
   assign d_gnt_s   = !reset && d_req && (force_d_s || !p_req);
   assign p_gnt_s   = !reset && p_req && !d_gnt_s;
   assign p_gnt     = p_gnt_s;
   assign d_gnt     = d_gnt_s;

   arb_starve_ctr #(
      .WIDTH (CNT_W),
      .MAX   (MAX_WAIT)
   ) u_starve_ctr (
      .clock (clock),
      .reset (reset),
      .clr   (d_gnt_s || !d_req),
      .inc   (d_req && !d_gnt_s),
      .cnt   (starve_cnt_s)
   );

   // RAM port mux: granted requester drives the port, idle port is all zero.
   always_comb begin
      wren         = 1'b0;
      address_dmem = '0;
      data         = '0;
      if (d_gnt_s) begin
         wren         = d_we;
         address_dmem = d_addr;
         data         = d_wdata;
      end else if (p_gnt_s) begin
         wren         = p_we;
         address_dmem = p_addr;
         data         = p_wdata;
      end else begin
         wren         = 1'b0;
         address_dmem = '0;
         data         = '0;
      end
   end

   // Owner of the read whose data the RAM returns on the following cycle.
   always_comb begin
      rd_owner_nxt_s = OWN_NONE;
      if (p_gnt_s && !p_we) begin
         rd_owner_nxt_s = OWN_PROC;
      end else if (d_gnt_s && !d_we) begin
         rd_owner_nxt_s = OWN_DBG;
      end else begin
         rd_owner_nxt_s = OWN_NONE;
      end
   end

   // Read-owner register; an async reset drops any response in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_owner_r <= OWN_NONE;
      end else begin
         rd_owner_r <= rd_owner_nxt_s;
      end
   end

   // Steer RAM read data to its owner only; the other side sees zero.
   always_comb begin
      p_rvalid = 1'b0;
      d_rvalid = 1'b0;
      p_rdata  = '0;
      d_rdata  = '0;
      case (rd_owner_r)
         OWN_PROC: begin
            p_rvalid = 1'b1;
            p_rdata  = q_dmem;
         end
         OWN_DBG: begin
            d_rvalid = 1'b1;
            d_rdata  = q_dmem;
         end
         default: begin
            p_rvalid = 1'b0;
            d_rvalid = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a transaction-level
// model of priority, bounded debug wait, RAM contents and read routing.
module tb_dmem_arbiter;

   localparam int ADDR_W   = 12;
   localparam int DATA_W   = 32;
   localparam int MAX_WAIT = 4;

   logic              clock;
   logic              reset;
   logic              p_req, p_we, d_req, d_we;
   logic [ADDR_W-1:0] p_addr, d_addr;
   logic [DATA_W-1:0] p_wdata, d_wdata;
   logic              p_gnt, p_rvalid, d_gnt, d_rvalid, wren;
   logic [DATA_W-1:0] p_rdata, d_rdata, data, q_dmem;
   logic [ADDR_W-1:0] address_dmem;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset(reset),
      .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .wren(wren), .address_dmem(address_dmem), .data(data), .q_dmem(q_dmem)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural 1-cycle-latency RAM.
   logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
   always @(posedge clock) begin
      if (wren) ram[address_dmem] <= data;
      q_dmem <= ram[address_dmem];
   end

   // Reference model state
   logic [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];
   int                denied;      // consecutive cycles debug asked and was refused
   int                resp_owner;  // 0 none, 1 proc, 2 debug (response due now)
   logic [DATA_W-1:0] resp_data;
   bit                last_pg, last_dg;

   int n_cmp, n_bad;

   task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: inputs already driven; check outputs, advance model.
   task automatic step(input bit rst_pulse);
      bit exp_dg, exp_pg, exp_we;
      logic [ADDR_W-1:0] exp_a;
      logic [DATA_W-1:0] exp_d;
      #1;
      exp_dg = d_req && ((denied >= MAX_WAIT) || !p_req);
      exp_pg = p_req && !exp_dg;
      exp_we = 1'b0; exp_a = '0; exp_d = '0;
      if (exp_dg) begin exp_we = d_we; exp_a = d_addr; exp_d = d_wdata; end
      else if (exp_pg) begin exp_we = p_we; exp_a = p_addr; exp_d = p_wdata; end
      check("p_gnt", 32'(p_gnt), 32'(exp_pg));
      check("d_gnt", 32'(d_gnt), 32'(exp_dg));
      check("wren", 32'(wren), 32'(exp_we));
      check("address_dmem", 32'(address_dmem), 32'(exp_a));
      check("data", data, exp_d);
      check("p_rvalid", 32'(p_rvalid), 32'(resp_owner == 1));
      check("d_rvalid", 32'(d_rvalid), 32'(resp_owner == 2));
      check("p_rdata", p_rdata, (resp_owner == 1) ? resp_data : 32'd0);
      check("d_rdata", d_rdata, (resp_owner == 2) ? resp_data : 32'd0);
      if (rst_pulse) begin
         #1;
         reset = 1'b1;
         p_req = 1'b0;
         d_req = 1'b0;
         #1;
         check("rst_p_gnt", 32'(p_gnt), 32'd0);
         check("rst_d_gnt", 32'(d_gnt), 32'd0);
         check("rst_p_rvalid", 32'(p_rvalid), 32'd0);
         check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
         check("rst_p_rdata", p_rdata, 32'd0);
         check("rst_d_rdata", d_rdata, 32'd0);
         check("rst_wren", 32'(wren), 32'd0);
         reset = 1'b0;
         resp_owner = 0;
         denied = 0;
         last_pg = 1'b0;
         last_dg = 1'b0;
      end else begin
         resp_owner = 0;
         if (exp_pg && !p_we) begin resp_owner = 1; resp_data = model_mem[p_addr]; end
         else if (exp_dg && !d_we) begin resp_owner = 2; resp_data = model_mem[d_addr]; end
         if (exp_we) model_mem[exp_a] = exp_d;
         if (exp_dg || !d_req) denied = 0;
         else if (denied < MAX_WAIT) denied++;
         last_pg = exp_pg;
         last_dg = exp_dg;
      end
      @(posedge clock);
      #1;
   endtask

   task automatic set_p(input bit req, input bit we, input int a, input logic [DATA_W-1:0] wd);
      p_req = req; p_we = we; p_addr = ADDR_W'(a); p_wdata = wd;
   endtask

   task automatic set_d(input bit req, input bit we, input int a, input logic [DATA_W-1:0] wd);
      d_req = req; d_we = we; d_addr = ADDR_W'(a); d_wdata = wd;
   endtask

   initial begin
      n_cmp = 0; n_bad = 0;
      denied = 0; resp_owner = 0; resp_data = '0;
      last_pg = 1'b0; last_dg = 1'b0;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         ram[i] = '0;
         model_mem[i] = '0;
      end
      reset = 1'b1;
      set_p(1'b0, 1'b0, 0, 32'd0);
      set_d(1'b0, 1'b0, 0, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      check("por_p_rvalid", 32'(p_rvalid), 32'd0);
      check("por_d_rvalid", 32'(d_rvalid), 32'd0);
      check("por_p_gnt", 32'(p_gnt), 32'd0);
      reset = 1'b0;

      // Processor write 0x2A @5 then read back
      set_p(1'b1, 1'b1, 5, 32'h2A); step(1'b0);
      set_p(1'b1, 1'b0, 5, 32'd0);  step(1'b0);
      set_p(1'b0, 1'b0, 0, 32'd0);
      check("proc_rd_42", p_rdata, 32'd42);
      step(1'b0);

      // Starvation: processor held, debug write 7 @9 forced in on cycle MAX_WAIT
      set_p(1'b1, 1'b0, 1, 32'd0);
      set_d(1'b1, 1'b1, 9, 32'd7);
      for (int c = 0; c <= MAX_WAIT; c++) begin
         step(1'b0);
         if (last_dg) set_d(1'b0, 1'b0, 0, 32'd0);
      end
      set_p(1'b0, 1'b0, 0, 32'd0);
      step(1'b0);
      check("mem9", ram[9], 32'd7);

      // Seed @1=11, @2=22, then alternate reads by owner
      set_p(1'b1, 1'b1, 1, 32'd11); step(1'b0);
      set_p(1'b1, 1'b1, 2, 32'd22); step(1'b0);
      for (int c = 0; c < 6; c++) begin
         set_p(c[0] == 1'b0, 1'b0, 1, 32'd0);
         set_d(c[0] == 1'b1, 1'b0, 2, 32'd0);
         step(1'b0);
      end
      set_p(1'b0, 1'b0, 0, 32'd0);
      set_d(1'b0, 1'b0, 0, 32'd0);
      step(1'b0);

      // Debug read alone, then debug read dropped by a reset pulse
      set_d(1'b1, 1'b0, 3, 32'd0); step(1'b0);
      set_d(1'b0, 1'b0, 0, 32'd0); step(1'b0);
      set_d(1'b1, 1'b0, 2, 32'd0); step(1'b1);
      set_p(1'b1, 1'b0, 1, 32'd0); step(1'b0);
      set_p(1'b0, 1'b0, 0, 32'd0);
      check("post_rst_proc_rd", p_rdata, 32'd11);
      step(1'b0);

      // Randomized traffic with held requests and occasional reset pulses
      for (int c = 0; c < 3000; c++) begin
         if (!p_req || last_pg || ($urandom_range(0, 15) == 0))
            set_p($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), $urandom);
         if (!d_req || last_dg || ($urandom_range(0, 15) == 0))
            set_d($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), $urandom);
         step($urandom_range(0, 199) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
